// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types and constants (frame states, parity modes).
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int MIN_DATA_LEN = 5;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Brief    : Counts oversampling ticks and pulses o_bit_end once per bit time.
// Revision : 1.0
// ============================================================================
module uart_bit_timer #(
    parameter int SAMPLING_TICKS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_bit_end
);

    localparam int CW = (SAMPLING_TICKS > 2) ? $clog2(SAMPLING_TICKS) : 1;

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last    = (r_count == CW'(SAMPLING_TICKS - 1));
    assign o_bit_end = i_tick & w_last & ~i_clear;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Brief    : Configurable-format UART transmitter with break generation.
// Revision : 1.0
// ============================================================================
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SAMPLING_TICKS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_baud_tick,
    input  logic [WIDTH-1:0]             i_tx_data,
    input  logic                         i_tx_valid,
    output logic                         o_tx_ready,
    input  logic [$clog2(WIDTH+1)-1:0]   i_cfg_data_len,
    input  logic [1:0]                   i_cfg_parity,
    input  logic                         i_cfg_stop2,
    input  logic                         i_break_req,
    output logic                         o_tx,
    output logic                         o_tx_busy,
    output logic                         o_tx_done
);

    localparam int LW = $clog2(WIDTH + 1);

    state_t           r_state,    w_state_n;
    logic [WIDTH-1:0] r_shift,    w_shift_n;
    logic [LW-1:0]    r_len,      w_len_n;
    logic [LW-1:0]    r_bit_cnt,  w_bit_cnt_n;
    logic             r_par_en,   w_par_en_n;
    logic             r_par_bit,  w_par_bit_n;
    logic             r_stop2,    w_stop2_n;
    logic             r_stop_cnt, w_stop_cnt_n;
    logic             r_tx,       w_tx_n;
    logic             r_ready,    w_ready_n;
    logic             r_busy,     w_busy_n;
    logic             r_done,     w_done_n;

    logic [LW-1:0]    w_len_eff;
    logic [WIDTH-1:0] w_mask;
    logic             w_par_data;
    logic             w_bit_end;
    logic             w_timer_clr;

    assign w_timer_clr = (r_state == ST_IDLE) || (r_state == ST_BREAK);

    uart_bit_timer #(
        .SAMPLING_TICKS (SAMPLING_TICKS)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_timer_clr),
        .i_tick    (i_baud_tick),
        .o_bit_end (w_bit_end)
    );

    // Out-of-range lengths fall back to the full payload width.
    always_comb begin
        w_len_eff = i_cfg_data_len;
        if (i_cfg_data_len < LW'(MIN_DATA_LEN) || i_cfg_data_len > LW'(WIDTH)) begin
            w_len_eff = LW'(WIDTH);
        end
        for (int i = 0; i < WIDTH; i++) begin
            w_mask[i] = (LW'(i) < w_len_eff);
        end
        w_par_data = ^(i_tx_data & w_mask);
    end

    always_comb begin
        w_state_n    = r_state;
        w_shift_n    = r_shift;
        w_len_n      = r_len;
        w_bit_cnt_n  = r_bit_cnt;
        w_par_en_n   = r_par_en;
        w_par_bit_n  = r_par_bit;
        w_stop2_n    = r_stop2;
        w_stop_cnt_n = r_stop_cnt;
        w_done_n     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (i_break_req) begin
                    w_state_n = ST_BREAK;
                end else if (i_tx_valid) begin
                    w_state_n    = ST_START;
                    w_shift_n    = i_tx_data;
                    w_len_n      = w_len_eff;
                    w_bit_cnt_n  = '0;
                    w_par_en_n   = (i_cfg_parity == PAR_EVEN) || (i_cfg_parity == PAR_ODD);
                    w_par_bit_n  = (i_cfg_parity == PAR_ODD) ? ~w_par_data : w_par_data;
                    w_stop2_n    = i_cfg_stop2;
                    w_stop_cnt_n = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) w_state_n = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_n   = r_shift >> 1;
                    w_bit_cnt_n = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == r_len - LW'(1)) begin
                        w_state_n = r_par_en ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) w_state_n = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_stop2 && !r_stop_cnt) begin
                        w_stop_cnt_n = 1'b1;
                    end else begin
                        w_state_n = ST_IDLE;
                        w_done_n  = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (!i_break_req) w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase

        w_ready_n = (w_state_n == ST_IDLE);
        w_busy_n  = (w_state_n != ST_IDLE);
    end

    // The line level follows the state already registered, hence one cycle behind it.
    always_comb begin
        w_tx_n = 1'b1;
        unique case (r_state)
            ST_START:  w_tx_n = 1'b0;
            ST_DATA:   w_tx_n = r_shift[0];
            ST_PARITY: w_tx_n = r_par_bit;
            ST_BREAK:  w_tx_n = 1'b0;
            default:   w_tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_len      <= '0;
            r_bit_cnt  <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_shift    <= w_shift_n;
            r_len      <= w_len_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_par_en   <= w_par_en_n;
            r_par_bit  <= w_par_bit_n;
            r_stop2    <= w_stop2_n;
            r_stop_cnt <= w_stop_cnt_n;
            r_tx       <= w_tx_n;
            r_ready    <= w_ready_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
        end
    end

    assign o_tx       = r_tx;
    assign o_tx_ready = r_ready;
    assign o_tx_busy  = r_busy;
    assign o_tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Brief    : Randomised scoreboard bench for uart_tx_frame (8-bit, 16x oversampling).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_frame;

    localparam int WIDTH = 8;
    localparam int ST    = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] cfg_data_len;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       break_req;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int n_vec = 0;
    int n_err = 0;
    int tick_mode = 0;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    frame_t exp_q[$];

    always #5 clk = ~clk;

    uart_tx_frame #(
        .WIDTH          (WIDTH),
        .SAMPLING_TICKS (ST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_baud_tick    (baud_tick),
        .i_tx_data      (tx_data),
        .i_tx_valid     (tx_valid),
        .o_tx_ready     (tx_ready),
        .i_cfg_data_len (cfg_data_len),
        .i_cfg_parity   (cfg_parity),
        .i_cfg_stop2    (cfg_stop2),
        .i_break_req    (break_req),
        .o_tx           (tx),
        .o_tx_busy      (tx_busy),
        .o_tx_done      (tx_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected line bits of one frame: start, data LSB first, optional parity, stops.
    function automatic frame_t model(input logic [7:0] d, input int len,
                                     input logic [1:0] par, input logic s2);
        frame_t f;
        int     l;
        int     ones;
        l    = (len < 5 || len > WIDTH) ? WIDTH : len;
        ones = 0;
        f.bits = '0;
        f.n    = 1;
        for (int i = 0; i < l; i++) begin
            f.bits[f.n] = d[i];
            ones += int'(d[i]);
            f.n++;
        end
        if (par == 2'b01) begin
            f.bits[f.n] = ((ones % 2) == 1);
            f.n++;
        end else if (par == 2'b10) begin
            f.bits[f.n] = ((ones % 2) == 0);
            f.n++;
        end
        f.bits[f.n] = 1'b1;
        f.n++;
        if (s2) begin
            f.bits[f.n] = 1'b1;
            f.n++;
        end
        return f;
    endfunction

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tick_mode)
                0:       baud_tick = 1'b1;
                1:       baud_tick = ($urandom_range(3) != 0);
                default: baud_tick = 1'b0;
            endcase
        end
    end

    // Monitor: counts baud ticks from each accepted payload, samples tx mid-bit,
    // and scores the captured frame whenever the DUT pulses tx_done.
    logic [15:0] got;
    int          got_n  = 0;
    int          ticks  = 0;
    bit          active = 1'b0;

    always @(negedge clk) begin
        frame_t e;
        if (tx_done) begin
            if (!active || exp_q.size() == 0) begin
                chk("unexpected_done", 32'(tx_done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("frame_bits", 32'(got), 32'(e.bits));
                chk("frame_nbits", 32'(got_n), 32'(e.n));
                chk("frame_ticks", 32'(ticks), 32'(ST * e.n));
            end
            active = 1'b0;
        end
        if (active && got_n < 16 && ticks == ST * got_n + ST / 2) begin
            got[got_n] = tx;
            got_n++;
        end
        if (rst) begin
            active = 1'b0;
        end else if (tx_valid && tx_ready && !break_req) begin
            active = 1'b1;
            ticks  = 0;
            got    = '0;
            got_n  = 0;
        end else if (active && baud_tick) begin
            ticks++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input int len, input logic [1:0] par,
                        input logic s2, input logic hold, output logic was_done);
        bit ok;
        int n;
        tx_data      = d;
        cfg_data_len = 4'(len);
        cfg_parity   = par;
        cfg_stop2    = s2;
        tx_valid     = 1'b1;
        ok = 1'b0;
        n  = 0;
        was_done = 1'b0;
        while (!ok && n < 20000) begin
            @(negedge clk);
            n++;
            if (tx_ready && !break_req && !rst) begin
                ok = 1'b1;
                was_done = tx_done;
            end
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        if (ok) exp_q.push_back(model(d, len, par, s2));
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!tx_done && n < 20000) begin
            cyc(1);
            n++;
        end
        chk("done_seen", 32'(tx_done), 32'd1);
    endtask

    initial begin
        logic wd;
        int   n;
        logic t0;

        rst          = 1'b1;
        tx_data      = '0;
        tx_valid     = 1'b0;
        cfg_data_len = 4'd8;
        cfg_parity   = 2'b00;
        cfg_stop2    = 1'b0;
        break_req    = 1'b0;
        cyc(3);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        rst = 1'b0;
        cyc(2);

        // 8N1 0xA5: exact frame length and handshake timing.
        send(8'hA5, 8, 2'b00, 1'b0, 1'b0, wd);
        chk("acc_busy", 32'(tx_busy), 32'd1);
        chk("acc_ready", 32'(tx_ready), 32'd0);
        wait_done(n);
        chk("8n1_cycles", 32'(n), 32'd160);
        chk("done_ready", 32'(tx_ready), 32'd1);
        cyc(1);
        chk("done_pulse_1cyc", 32'(tx_done), 32'd0);

        send(8'h41, 7, 2'b01, 1'b1, 1'b0, wd);
        send(8'h00, 8, 2'b10, 1'b0, 1'b0, wd);
        send(8'hFF, 8, 2'b10, 1'b0, 1'b0, wd);
        send(8'h01, 8, 2'b01, 1'b0, 1'b0, wd);
        wait_done(n);
        cyc(3);

        // Back-to-back with tx_valid held.
        send(8'h55, 8, 2'b00, 1'b0, 1'b1, wd);
        send(8'h33, 8, 2'b00, 1'b0, 1'b0, wd);
        chk("b2b_accept_on_done", 32'(wd), 32'd1);
        chk("b2b_busy", 32'(tx_busy), 32'd1);
        wait_done(n);
        cyc(3);

        // Config change mid-frame must not alter the frame in flight.
        send(8'hE7, 8, 2'b00, 1'b0, 1'b0, wd);
        cyc(40);
        cfg_data_len = 4'd5;
        cfg_parity   = 2'b01;
        cfg_stop2    = 1'b1;
        wait_done(n);
        cyc(3);

        // Break requested mid-frame is deferred until the frame ends.
        send(8'h96, 8, 2'b00, 1'b0, 1'b0, wd);
        cyc(50);
        break_req = 1'b1;
        wait_done(n);
        cyc(2);
        chk("brk_tx", 32'(tx), 32'd0);
        chk("brk_busy", 32'(tx_busy), 32'd1);
        chk("brk_ready", 32'(tx_ready), 32'd0);
        cyc(30);
        chk("brk_hold_tx", 32'(tx), 32'd0);
        break_req = 1'b0;
        cyc(2);
        chk("brk_rel_tx", 32'(tx), 32'd1);
        chk("brk_rel_ready", 32'(tx_ready), 32'd1);
        chk("brk_rel_busy", 32'(tx_busy), 32'd0);

        // Break has priority over a simultaneous payload.
        tx_data   = 8'hC9;
        tx_valid  = 1'b1;
        break_req = 1'b1;
        cyc(2);
        chk("prio_tx", 32'(tx), 32'd0);
        chk("prio_ready", 32'(tx_ready), 32'd0);
        cyc(10);
        break_req = 1'b0;
        send(8'hC9, 6, 2'b10, 1'b1, 1'b0, wd);
        wait_done(n);
        cyc(2);

        // No ticks: the frame freezes.
        send(8'h5A, 8, 2'b00, 1'b0, 1'b0, wd);
        cyc(40);
        tick_mode = 2;
        cyc(3);
        t0 = tx;
        cyc(60);
        chk("stall_tx", 32'(tx), 32'(t0));
        chk("stall_busy", 32'(tx_busy), 32'd1);
        tick_mode = 0;
        wait_done(n);
        cyc(2);

        // Reset during data bit 3 aborts the frame silently.
        send(8'hC3, 8, 2'b00, 1'b0, 1'b0, wd);
        cyc(ST * 4 + 6);
        rst = 1'b1;
        exp_q.delete();
        cyc(1);
        rst = 1'b0;
        chk("mrst_tx", 32'(tx), 32'd1);
        chk("mrst_busy", 32'(tx_busy), 32'd0);
        chk("mrst_ready", 32'(tx_ready), 32'd1);
        chk("mrst_done", 32'(tx_done), 32'd0);
        cyc(5);
        send(8'h3C, 8, 2'b00, 1'b0, 1'b0, wd);
        wait_done(n);
        cyc(2);

        // Randomised frames, formats, tick density and handshake gaps.
        for (int k = 0; k < 40; k++) begin
            tick_mode = int'($urandom_range(1));
            cyc(int'($urandom_range(3)));
            send(8'($urandom), int'($urandom_range(15)), 2'($urandom_range(3)),
                 1'($urandom_range(1)), 1'($urandom_range(1)), wd);
        end
        tx_valid  = 1'b0;
        tick_mode = 0;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 20000) begin
            cyc(1);
            n++;
        end
        cyc(2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(800_000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Next-generation UART transmitter, replacing the fixed-format transmit core. Frame format is runtime-configurable: 5..WIDTH data bits, none/even/odd parity, 1 or 2 stop bits.
Data is accepted with a valid/ready handshake and a frame-done pulse is issued at the end of each frame. A line-break mode holds tx low on request.
Sits between the TX FIFO/register interface and the tx pin, and is driven by the shared oversampling baud-tick generator.

Parameters:
WIDTH, 8, maximum data bits per frame (range 5..9)
SAMPLING_TICKS, 16, baud_tick pulses per bit time (at least 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
baud_tick  input  1  one-cycle oversampling tick
tx_data  input  WIDTH  frame payload, transmitted LSB first
tx_valid  input  1  payload valid
tx_ready  output  1  block can accept a payload
cfg_data_len  input  $clog2(WIDTH+1)  number of data bits
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  input  1  0 selects one stop bit, 1 selects two
break_req  input  1  request to hold the line low
tx  output  1  serial line
tx_busy  output  1  frame or break in progress
tx_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Reset is sampled on the clk edge and overrides everything, including mid-frame.
- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- Outputs are registered. tx reflects the current state's bit value one cycle after the state is entered.
- Acceptance (IDLE, tx_ready=1, tx_valid=1, break_req=0):
  - Latch tx_data, cfg_data_len, cfg_parity and cfg_stop2.
  - Go to START; next cycle tx_ready=0, tx_busy=1.
  - Config changes after acceptance have no effect on the frame in progress.
- Length clamp: a latched cfg_data_len below 5 or above WIDTH is treated as WIDTH.
- Bit time: each bit lasts exactly SAMPLING_TICKS baud_ticks. The tick counter increments only on baud_tick. On the tick where count = SAMPLING_TICKS-1, the counter resets to 0 and the bit advances.
- START: tx=0. Advance to DATA.
- DATA: tx=shift[0]; shift right on each bit advance. After data_len bits, go to PARITY if parity is enabled, else STOP.
- PARITY: tx = XOR of the data_len data bits (even), or its inverse (odd). Unused high bits are excluded.
- STOP: tx=1 for 1 or 2 bit times.
  - On the final stop-bit advance: state=IDLE, tx_done=1 for exactly one cycle, tx_ready=1 in the same cycle.
- Back-to-back frames: if tx_valid is held high, the next frame's START begins the cycle after tx_done. No idle bit is inserted.
- Break:
  - In IDLE with break_req=1: go to BREAK, tx=0, tx_busy=1, tx_ready=0.
  - Stay in BREAK while break_req=1. When break_req falls, return to IDLE with tx=1.
  - break_req has priority over tx_valid when both are high in IDLE.
  - break_req during a frame is ignored until the frame completes; if still high then, BREAK is entered.
  - tx_done is not pulsed for a break.
- No baud_tick: state holds indefinitely. The counter never wraps without a tick.
- Frame length in bit times: 1 + data_len + (parity?1:0) + (stop2?2:1).

Decomposition:
- Package uart_pkg holds:
  - state enumeration
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD
  - MIN_DATA_LEN=5
- One sub-module, uart_bit_timer: baud_tick counter with SAMPLING_TICKS parameter, clear input and bit_end pulse output. It is reused by the future RX core.
- Parity is computed inline.

Test Plan:
- 8N1, 0xA5, baud_tick every cycle, SAMPLING_TICKS=16 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1; each bit 16 cycles, 160 cycles total; tx_done pulses once; tx_ready returns to 1.
- 7E2, 0x41 -> sequence 0,1,0,0,0,0,0,1,0,1,1; parity=0; 11 bit times.
- 8O1, 0x00 -> parity bit 1. 8O1, 0xFF -> parity bit 1. 8E1, 0x01 -> parity bit 1.
- tx_valid held high with payloads 0x55 then 0x33 -> second START begins the cycle after the first tx_done; exactly two tx_done pulses; no extra idle.
- Config and break interactions:
  - Change cfg_data_len from 8 to 5 mid-frame -> current frame still carries 8 data bits.
  - Assert break_req mid-frame -> frame completes, then tx=0 for as long as break_req is held.
  - Release break_req -> tx=1 and tx_ready=1.
- Reset: assert rst during DATA bit 3 -> next cycle tx=1, tx_busy=0, tx_ready=0→1 per reset values; tx_done is not pulsed. A following 0x3C frame transmits correctly.
